// File: rtl/hilo_ctrl.sv
// HI/LO register file with a sequencer for an external multi-cycle divider.
// Handles mthi/mtlo writes, the divider reset pulse, the run count, and result capture.
module hilo_ctrl #(
  parameter int DIV_CYCLES = 34
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_start,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_exc,
  output logic        div_rst,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam int CW = $clog2(DIV_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CLR, RUN, CAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          exc_hit;  // CAP was reached through div_exc, not count completion

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      exc_hit  <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      div_rst  <= 1'b0;
    end else begin
      div_rst <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) HI <= wdata;
          if (mtlo) LO <= wdata;
          if (div_start) begin
            state    <= CLR;
            div_rst  <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
            div_zero <= 1'b0;
            exc_hit  <= 1'b0;
          end
        end
        CLR: begin
          state <= RUN;
          cnt   <= '0;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          // a divide-by-zero flag wins over a simultaneous count completion
          if (div_exc) begin
            exc_hit <= 1'b1;
            state   <= CAP;
            done    <= 1'b1;
          end else if (cnt == LAST) begin
            state <= CAP;
            done  <= 1'b1;
          end
        end
        CAP: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (exc_hit) div_zero <= 1'b1;
          else begin
            HI <= div_hi;
            LO <= div_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl: a small divider model answers div_rst, and
// expected results are queued at div_start and retired on each done pulse.
module tb_hilo_ctrl;
  localparam int D = 34;

  logic        clk = 1'b0;
  logic        reset, div_start, mthi, mtlo, div_exc;
  logic [31:0] wdata, div_hi, div_lo;
  logic        div_rst, busy, done, div_zero;
  logic [31:0] HI, LO;

  hilo_ctrl #(.DIV_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .div_start(div_start), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .div_hi(div_hi), .div_lo(div_lo), .div_exc(div_exc),
    .div_rst(div_rst), .HI(HI), .LO(LO), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          done_cyc;
    int          busy_len;
  } exp_t;

  exp_t q[$];
  int   npass = 0, ntot = 0;
  int   cyc = 0;
  int   mcnt;
  logic exc_mode = 1'b0;
  logic cap_pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // divider model: counts RUN cycles after its reset pulse, optionally flags div-by-zero
  always @(posedge clk or posedge reset)
    if (reset)                    mcnt <= 0;
    else if (div_rst)             mcnt <= 1;
    else if (mcnt != 0 && mcnt < 1000) mcnt <= mcnt + 1;
  assign div_exc = exc_mode && (mcnt == 3);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else npass++;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // queue expectation for a division started by the div_start driven at this negedge
  task automatic push(input logic [31:0] hi, input logic [31:0] lo, input logic dz, input int blen);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = dz; e.busy_len = blen;
    e.done_cyc = cyc + blen;
    q.push_back(e);
  endtask

  task automatic start_div;
    div_start = 1'b1;
    tick;
    div_start = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 200 && (q.size() != 0 || cap_pend); i++) tick;
    tick;
    chk("drain", q.size() + int'(cap_pend), 0);
  endtask

  // monitor: retire one expectation per done pulse, then check the captured state
  initial begin
    int   busy_cnt = 0, rst_cnt = 0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++; else busy_cnt = 0;
      if (!busy) rst_cnt = 0; else if (div_rst) rst_cnt++;
      if (cap_pend) begin
        chk("HI_after", HI, cur.hi);
        chk("LO_after", LO, cur.lo);
        chk("dz_after", {31'b0, div_zero}, {31'b0, cur.dz});
        chk("done_width", {31'b0, done}, 32'd0);
        chk("busy_after", {31'b0, busy}, 32'd0);
        cap_pend = 1'b0;
      end
      if (done) begin
        if (q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
        else begin
          cur = q.pop_front();
          chk("done_cyc", cyc, cur.done_cyc);
          chk("busy_len", busy_cnt, cur.busy_len);
          chk("rst_pulses", rst_cnt, 32'd1);
          cap_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; div_start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    wdata = '0; div_hi = 32'd2; div_lo = 32'd14;
    tick; tick;
    chk("rst_HI", HI, 0); chk("rst_LO", LO, 0);
    chk("rst_flags", {28'b0, busy, done, div_zero, div_rst}, 0);
    reset = 1'b0;
    tick;

    // mthi / mtlo in IDLE
    mthi = 1'b1; wdata = 32'hDEADBEEF; tick; mthi = 1'b0;
    chk("mthi", HI, 32'hDEADBEEF);
    mtlo = 1'b1; wdata = 32'h12345678; tick; mtlo = 1'b0;
    chk("mtlo", LO, 32'h12345678);
    chk("mtlo_keepHI", HI, 32'hDEADBEEF);

    // normal division; a second start and an mthi mid-RUN are ignored
    push(32'd2, 32'd14, 1'b0, D + 2);
    start_div;
    chk("clr_rst", {31'b0, div_rst}, 1);
    chk("clr_busy", {31'b0, busy}, 1);
    repeat (5) tick;
    div_start = 1'b1; mthi = 1'b1; wdata = 32'hFFFFFFFF;
    tick;
    div_start = 1'b0; mthi = 1'b0;
    chk("run_mthi_ign", HI, 32'hDEADBEEF);
    chk("run_rst_low", {31'b0, div_rst}, 0);
    drain;

    // both writes together, then preload 0x55/0xAA for the div-by-zero case
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h77; tick; mthi = 1'b0; mtlo = 1'b0;
    chk("both_HI", HI, 32'h77); chk("both_LO", LO, 32'h77);
    mthi = 1'b1; wdata = 32'h55; tick; mthi = 1'b0;
    mtlo = 1'b1; wdata = 32'hAA; tick; mtlo = 1'b0;
    exc_mode = 1'b1;
    push(32'h55, 32'hAA, 1'b1, 5);
    start_div;
    drain;
    exc_mode = 1'b0;
    repeat (3) tick;
    chk("dz_sticky", {31'b0, div_zero}, 1);

    // start with a same-cycle mthi: write lands, div_zero clears in CLR, result overwrites
    div_hi = 32'd3; div_lo = 32'd33;
    push(32'd3, 32'd33, 1'b0, D + 2);
    mthi = 1'b1; wdata = 32'h11111111;
    start_div;
    mthi = 1'b0;
    chk("start_mthi", HI, 32'h11111111);
    chk("clr_dz", {31'b0, div_zero}, 0);
    drain;

    // asynchronous reset at RUN cycle 10 aborts the division
    push(32'd0, 32'd0, 1'b0, D + 2);
    start_div;
    repeat (10) tick;
    #2 reset = 1'b1;
    #1;
    void'(q.pop_front());
    chk("arst_HI", HI, 0); chk("arst_LO", LO, 0);
    chk("arst_flags", {28'b0, busy, done, div_zero, div_rst}, 0);
    #3 reset = 1'b0;
    repeat (40) tick;
    chk("post_rst_idle", {31'b0, busy}, 0);

    // fresh division after the abort
    div_hi = 32'd2; div_lo = 32'd14;
    push(32'd2, 32'd14, 1'b0, D + 2);
    start_div;
    drain;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameter DIV_CYCLES, default 34, number of RUN-state cycles the divider needs after its reset pulse before HI/LO are valid.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 div_start  input  1  request to start a division, sampled on rising edge.
REQ-005 mthi  input  1  write wdata into HI.
REQ-006 mtlo  input  1  write wdata into LO.
REQ-007 wdata  input  32  data for mthi/mtlo.
REQ-008 div_hi  input  32  remainder from divider.
REQ-009 div_lo  input  32  quotient from divider.
REQ-010 div_exc  input  1  divider divide-by-zero flag.
REQ-011 div_rst  output  1  synchronous reset pulse to divider.
REQ-012 HI  output  32  architectural HI register.
REQ-013 LO  output  32  architectural LO register.
REQ-014 busy  output  1  division in progress; pipeline stalls on it.
REQ-015 done  output  1  one-cycle pulse: division finished.
REQ-016 div_zero  output  1  sticky divide-by-zero status of last division.

Function
REQ-017 FSM states: IDLE, CLR, RUN, CAP; encoding free.
REQ-018 IDLE: div_start=1 -> CLR next edge; otherwise stay.
REQ-019 CLR: div_rst=1 for exactly this cycle; cycle counter loaded with 0; div_zero cleared; -> RUN.
REQ-020 RUN: counter increments every cycle; -> CAP on the edge where counter == DIV_CYCLES-1, or on the first edge where div_exc=1, whichever comes first.
REQ-021 CAP: done=1 for this cycle only; -> IDLE next edge.
REQ-022 CAP entered by count completion: HI<=div_hi, LO<=div_lo on the edge leaving CAP; div_zero stays 0.
REQ-023 CAP entered by div_exc: HI and LO unchanged; div_zero<=1 on the edge leaving CAP, held until next CLR or reset.
REQ-024 busy=1 in CLR, RUN, CAP; busy=0 in IDLE; div_rst=0 in all states except CLR.
REQ-025 Latency: div_start at edge N -> CLR during cycle N..N+1, RUN for DIV_CYCLES cycles, done high in cycle N+DIV_CYCLES+1, new HI/LO visible from edge N+DIV_CYCLES+2.
REQ-026 mthi/mtlo in IDLE: register written with wdata on next edge; both asserted together write both.
REQ-027 mthi/mtlo while busy=1: ignored, no register change.
REQ-028 div_start while busy=1: ignored, no restart, no queuing.
REQ-029 div_start with mthi/mtlo in same IDLE cycle: write performed and division accepted; division result later overwrites both HI and LO.
REQ-030 Counter width: ceil(log2(DIV_CYCLES))+1 bits, never wraps within RUN.
REQ-031 div_exc outside RUN ignored.

Reset
REQ-032 reset=1 forces, asynchronously: state=IDLE, counter=0, HI=0, LO=0, busy=0, done=0, div_zero=0, div_rst=0.
REQ-033 reset asserted mid-RUN or CAP aborts division; HI/LO=0, no done pulse afterwards; after release the block accepts div_start normally.
REQ-034 Outputs change only on reset assertion or rising clk edge; no combinational path from inputs to outputs except none (all outputs registered or state-decoded).

Verification
REQ-035 Divider model gives div_lo=14, div_hi=2 (100/7); pulse div_start -> div_rst one cycle, busy high 36 cycles, done one cycle, then LO=14, HI=2, div_zero=0.
REQ-036 Model asserts div_exc in 3rd RUN cycle; HI=0x55, LO=0xAA preloaded -> done pulse, busy drops early, HI=0x55, LO=0xAA, div_zero=1; next div_start clears div_zero in CLR.
REQ-037 IDLE: mthi with wdata=0xDEADBEEF, then mtlo with wdata=0x12345678 -> HI=0xDEADBEEF, LO=0x12345678; mthi during RUN with 0xFFFFFFFF -> HI unchanged.
REQ-038 Reset pulsed (not clock-aligned) at RUN cycle 10 -> all outputs 0 immediately, no done; fresh division afterwards completes with correct HI/LO.
REQ-039 Second div_start at RUN cycle 5 -> ignored; single done at original time, counter not restarted.
